nand_bus_arbiter: RTL and testbench
===================================

Name: nand_bus_arbiter

Overview:
- Per-bus arbiter sharing one NAND bus among NUM_CHIPS chip targets. The shared bus is DQ/DQS/CLE/ALE/WRN/WPN plus the shared WEN/NCLK.
- Each target has its own CE_n and R/B_n line. Per-target command sequencers request the bus here.
- The block grants ownership round-robin, drives the CE_n vector and inserts bus-turnaround gaps.
- It synchronizes R/B_n so that requesters can wait for chip-ready before they are granted.
- One instance per bus sits inside the flash controller, between the per-chip sequencers and the bus PHY.

Parameters:
- NUM_CHIPS, 8, number of chip targets (CE lines) on the bus; power of two, 2..16.
- TURN_CYCLES, 2, idle cycles with all CE_n high between consecutive grants; 0..7.
- HOLD_LIMIT, 1024, watchdog hold limit in cycles; used only with NAND_ARB_WATCHDOG_EN.

Ports:
- CLK  in  1  single system clock; all logic is on its rising edge.
- RST  in  1  synchronous, active-high reset.
- req  in  NUM_CHIPS  per-target bus request; level, held until granted.
- req_wait_rdy  in  NUM_CHIPS  the target is eligible only when chip_ready[i]=1; sampled together with req.
- release  in  NUM_CHIPS  one-cycle pulse from the current owner ending its ownership.
- rb_n  in  NUM_CHIPS  asynchronous R/B_n from the chips (1 = ready).
- gnt  out  NUM_CHIPS  one-hot grant, held for the whole ownership.
- gnt_valid  out  1  OR of gnt.
- gnt_id  out  log2(NUM_CHIPS)  index of the current owner; 0 when none.
- cen  out  NUM_CHIPS  active-low chip enables: ~gnt, all ones when there is no owner.
- chip_ready  out  NUM_CHIPS  rb_n after the 2-flop synchronizer.
- timeout_err  out  1  one-cycle pulse on a watchdog-forced release (0 without the feature).

Behaviour:
- Reset values: gnt=0, gnt_valid=0, gnt_id=0, cen=all ones, chip_ready=0 (synchronizer flops cleared), timeout_err=0, state=IDLE, priority pointer=0, counters=0.
- Eligibility: elig[i] = req[i] & (~req_wait_rdy[i] | chip_ready[i]).
- chip_ready latency: 2 cycles from a rb_n edge.
- States:
  - IDLE: if any elig, pick the first eligible index searching upward circularly from the pointer. Register gnt, gnt_id and cen in the next cycle, so grant latency is 1 cycle from req. Go to OWN.
  - OWN: hold the grant. A release pulse from the owner (release[gnt_id]) goes to TURN and clears gnt/cen in the next cycle. The pointer becomes gnt_id+1, wrapping to 0 after NUM_CHIPS-1.
  - TURN: count TURN_CYCLES cycles with no owner, then go to IDLE. With TURN_CYCLES=0, skip TURN and go straight to IDLE.
- Boundary conditions:
  - A release on a non-owner index is ignored.
  - A release in IDLE or TURN is ignored.
  - A req dropped before grant is simply not granted; no state change.
  - If the owner drops req while in OWN, it keeps the grant until release.
  - A release in the same cycle as another target's new req: the new target is arbitrated only after TURN.
  - The owner re-requests in the same cycle as its release: it is lowest priority in the next arbitration (fairness).
  - A target that has req high and req_wait_rdy high with chip_ready low is skipped. It does not block the others.
  - All targets requesting continuously: grants rotate 0,1,...,NUM_CHIPS-1,0.
- Invariants: gnt is never multi-hot; cen==~gnt at all times.
- Reset asserted mid-ownership: the next edge forces the reset values and cen goes all ones. Requesters must re-request.

Optional Feature:
- Macro NAND_ARB_WATCHDOG_EN.
- Defined:
  - A hold counter counts cycles in OWN and clears on entry to OWN.
  - When the counter reaches HOLD_LIMIT-1 without a release, the arbiter forces a release. It pulses timeout_err for 1 cycle, goes to TURN and advances the pointer as for a normal release.
  - A release in the same cycle as the limit counts as a normal release, with no error.
- Not defined: no counter, timeout_err is tied 0, and ownership is unbounded.

Decomposition:
- Package nand_bus_pkg holds:
  - arb_state_t enum {IDLE, OWN, TURN};
  - constant CHIP_ID_W = log2(NUM_CHIPS) for the default configuration;
  - constant RB_SYNC_STAGES = 2.
- Sub-module rr_pick: purely combinational circular priority search. Inputs are elig and the pointer; outputs are a one-hot vector and a found flag. It is reused later by the plane/way scheduler.

Test Plan:
- Reset, then req=8'h01 at cycle 10 -> gnt=8'h01, cen=8'hFE, gnt_id=0 at cycle 11. release[0] at cycle 20 -> cen=8'hFF at cycle 21, through cycle 22 (TURN_CYCLES=2).
- req=8'hFF held, each owner releases 3 cycles after its grant -> gnt_id sequence 0,1,2,...,7,0. Each grant is separated by exactly 2 all-high-CE cycles.
- req=8'h06, req_wait_rdy=8'h02, rb_n[1]=0 -> target 2 is granted. Raise rb_n[1] -> chip_ready[1]=1 two cycles later. Target 1 is granted after target 2's release plus turnaround.
- Owner 3, then release[5] pulse and a release in IDLE -> no change. RST high for 1 cycle mid-OWN -> next cycle gnt=0, cen=8'hFF, chip_ready=0.
- NAND_ARB_WATCHDOG_EN, HOLD_LIMIT=16, owner 4 never releases -> timeout_err pulses at the 16th OWN cycle, cen=8'hFF next cycle, pointer=5. Without the macro: grant held for 100 cycles and timeout_err stays 0.

Source files
------------

// File: rtl/nand_bus_arbiter_pkg.sv
// Shared types and constants for the NAND bus arbiter and its schedulers.
package nand_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } arb_state_t;

    localparam int unsigned CHIP_ID_W      = 3;
    localparam int unsigned RB_SYNC_STAGES = 2;

endpackage

// File: rtl/nand_bus_arbiter_rr_pick.sv
// Combinational circular priority search: first set bit of elig at or above ptr, wrapping.
module rr_pick #(
    parameter  int unsigned N     = 8,
    localparam int unsigned PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     elig,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic             found
);

    logic [PTR_W-1:0] idx;

    // N is a power of two, so the PTR_W-bit add wraps the search circularly.
    always_comb begin
        onehot = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = ptr + PTR_W'(i);
            if (!found && elig[idx]) begin
                onehot[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nand_bus_arbiter.sv
// Round-robin owner arbitration for one shared NAND bus, with CE_n drive, turnaround gaps
// and R/B_n synchronisation. Optional hold watchdog: define NAND_ARB_WATCHDOG_EN.
module nand_bus_arbiter
    import nand_bus_pkg::*;
#(
    parameter  int unsigned NUM_CHIPS   = 8,
    parameter  int unsigned TURN_CYCLES = 2,
    parameter  int unsigned HOLD_LIMIT  = 1024,
    localparam int unsigned ID_W        = $clog2(NUM_CHIPS)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NUM_CHIPS-1:0] req,
    input  logic [NUM_CHIPS-1:0] req_wait_rdy,
    // "release" is a reserved word in SystemVerilog, hence the suffix.
    input  logic [NUM_CHIPS-1:0] release_pulse,
    input  logic [NUM_CHIPS-1:0] rb_n,
    output logic [NUM_CHIPS-1:0] gnt,
    output logic                 gnt_valid,
    output logic [ID_W-1:0]      gnt_id,
    output logic [NUM_CHIPS-1:0] cen,
    output logic [NUM_CHIPS-1:0] chip_ready,
    output logic                 timeout_err
);

    localparam logic [2:0] TURN_LAST = (TURN_CYCLES == 0) ? 3'd0 : 3'(TURN_CYCLES - 1);

    arb_state_t            state, state_d;
    logic [ID_W-1:0]       ptr, ptr_d;
    logic [2:0]            turn_cnt, turn_cnt_d;
    logic [NUM_CHIPS-1:0]  gnt_d;
    logic [ID_W-1:0]       gnt_id_d;
    logic [NUM_CHIPS-1:0]  rb_sync [RB_SYNC_STAGES];
    logic [NUM_CHIPS-1:0]  elig;
    logic [NUM_CHIPS-1:0]  pick_oh;
    logic                  pick_found;
    logic [ID_W-1:0]       pick_id;
    logic                  owner_rel;
    logic                  arbitrate;
    logic                  force_rel;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned s = 0; s < RB_SYNC_STAGES; s++)
                rb_sync[s] <= '0;
        end else begin
            rb_sync[0] <= rb_n;
            for (int unsigned s = 1; s < RB_SYNC_STAGES; s++)
                rb_sync[s] <= rb_sync[s-1];
        end
    end

    assign chip_ready = rb_sync[RB_SYNC_STAGES-1];
    assign elig       = req & (~req_wait_rdy | chip_ready);
    assign owner_rel  = release_pulse[gnt_id];

    rr_pick #(.N(NUM_CHIPS)) u_pick (
        .elig   (elig),
        .ptr    (ptr),
        .onehot (pick_oh),
        .found  (pick_found)
    );

    always_comb begin
        pick_id = '0;
        for (int unsigned i = 0; i < NUM_CHIPS; i++)
            if (pick_oh[i]) pick_id = ID_W'(i);
    end

`ifdef NAND_ARB_WATCHDOG_EN
    localparam int unsigned HOLD_W    = $clog2(HOLD_LIMIT + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LIMIT - 1);

    logic [HOLD_W-1:0] hold_cnt;

    assign force_rel = (state == OWN) && (hold_cnt == HOLD_LAST) && !owner_rel;

    always_ff @(posedge CLK) begin
        if (RST || state != OWN) hold_cnt <= '0;
        else                     hold_cnt <= hold_cnt + HOLD_W'(1);
    end
`else
    assign force_rel = 1'b0;
`endif

    assign timeout_err = force_rel;

    // The final TURN cycle arbitrates directly, so a waiting requester sees exactly
    // TURN_CYCLES all-high CE cycles between owners instead of TURN_CYCLES + 1.
    assign arbitrate = (state == IDLE) || ((state == TURN) && (turn_cnt == TURN_LAST));

    always_comb begin
        state_d    = state;
        ptr_d      = ptr;
        turn_cnt_d = turn_cnt;
        gnt_d      = gnt;
        gnt_id_d   = gnt_id;
        case (state)
            OWN: begin
                if (owner_rel || force_rel) begin
                    gnt_d      = '0;
                    gnt_id_d   = '0;
                    ptr_d      = gnt_id + ID_W'(1);
                    turn_cnt_d = '0;
                    state_d    = (TURN_CYCLES == 0) ? IDLE : TURN;
                end
            end
            TURN: begin
                if (turn_cnt != TURN_LAST) turn_cnt_d = turn_cnt + 3'd1;
                else                       state_d    = IDLE;
            end
            default: ;
        endcase
        if (arbitrate && pick_found) begin
            state_d  = OWN;
            gnt_d    = pick_oh;
            gnt_id_d = pick_id;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            ptr      <= '0;
            turn_cnt <= '0;
            gnt      <= '0;
            gnt_id   <= '0;
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            turn_cnt <= turn_cnt_d;
            gnt      <= gnt_d;
            gnt_id   <= gnt_id_d;
        end
    end

    assign gnt_valid = |gnt;
    assign cen       = ~gnt;

endmodule

// File: tb/tb_nand_bus_arbiter.sv
// Directed bench for nand_bus_arbiter (8 chips, 2 turnaround cycles, hold limit 16).
module tb_nand_bus_arbiter;

    logic       CLK;
    logic       RST;
    logic [7:0] req;
    logic [7:0] req_wait_rdy;
    logic [7:0] release_pulse;
    logic [7:0] rb_n;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_id;
    logic [7:0] cen;
    logic [7:0] chip_ready;
    logic       timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    nand_bus_arbiter #(
        .NUM_CHIPS   (8),
        .TURN_CYCLES (2),
        .HOLD_LIMIT  (16)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .req           (req),
        .req_wait_rdy  (req_wait_rdy),
        .release_pulse (release_pulse),
        .rb_n          (rb_n),
        .gnt           (gnt),
        .gnt_valid     (gnt_valid),
        .gnt_id        (gnt_id),
        .cen           (cen),
        .chip_ready    (chip_ready),
        .timeout_err   (timeout_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        n_tests++; if (gnt !== 8'h00) begin n_fail++; $display("FAIL rst_gnt: got %h want 00", gnt); end
        n_tests++; if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_gnt_valid: got %b want 0", gnt_valid); end
        n_tests++; if (gnt_id !== 3'd0) begin n_fail++; $display("FAIL rst_gnt_id: got %0d want 0", gnt_id); end
        n_tests++; if (cen !== 8'hFF) begin n_fail++; $display("FAIL rst_cen: got %h want FF", cen); end
        n_tests++; if (chip_ready !== 8'h00) begin n_fail++; $display("FAIL rst_chip_ready: got %h want 00", chip_ready); end
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b want 0", timeout_err); end
        RST = 1'b0;
        tick();
        n_tests++; if (chip_ready !== 8'h00) begin n_fail++; $display("FAIL sync_lat1: got %h want 00", chip_ready); end
        tick();
        n_tests++; if (chip_ready !== 8'hFF) begin n_fail++; $display("FAIL sync_lat2: got %h want FF", chip_ready); end
    endtask

    task automatic test_single();
        req = 8'h01;
        tick();
        n_tests++; if (gnt !== 8'h01) begin n_fail++; $display("FAIL single_gnt: got %h want 01", gnt); end
        n_tests++; if (cen !== 8'hFE) begin n_fail++; $display("FAIL single_cen: got %h want FE", cen); end
        n_tests++; if (gnt_id !== 3'd0) begin n_fail++; $display("FAIL single_id: got %0d want 0", gnt_id); end
        n_tests++; if (gnt_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", gnt_valid); end
        req = 8'h00;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_tests++; if (gnt !== 8'h01) begin n_fail++; $display("FAIL single_hold c%0d: got %h want 01", c, gnt); end
        end
        release_pulse = 8'h01;
        tick();
        release_pulse = 8'h00;
        for (int c = 0; c < 3; c++) begin
            n_tests++; if (cen !== 8'hFF) begin n_fail++; $display("FAIL single_turn c%0d: got %h want FF", c, cen); end
            tick();
        end
    endtask

    task automatic test_rotation();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        req = 8'hFF;
        tick();
        for (int k = 0; k < 9; k++) begin
            int e;
            e = k % 8;
            n_tests++; if (gnt_id !== 3'(e)) begin n_fail++; $display("FAIL rot_id k%0d: got %0d want %0d", k, gnt_id, e); end
            n_tests++; if (gnt !== 8'(1 << e)) begin n_fail++; $display("FAIL rot_gnt k%0d: got %h want %h", k, gnt, 8'(1 << e)); end
            n_tests++; if (cen !== ~8'(1 << e)) begin n_fail++; $display("FAIL rot_cen k%0d: got %h want %h", k, cen, ~8'(1 << e)); end
            tick();
            tick();
            release_pulse = 8'(1 << e);
            if (k == 8) req = 8'h00;
            tick();
            release_pulse = 8'h00;
            n_tests++; if (cen !== 8'hFF) begin n_fail++; $display("FAIL rot_gap1 k%0d: got %h want FF", k, cen); end
            tick();
            n_tests++; if (cen !== 8'hFF) begin n_fail++; $display("FAIL rot_gap2 k%0d: got %h want FF", k, cen); end
            tick();
        end
        n_tests++; if (gnt !== 8'h00) begin n_fail++; $display("FAIL rot_end: got %h want 00", gnt); end
    endtask

    task automatic test_wait_rdy();
        rb_n = 8'hFD;
        tick();
        tick();
        n_tests++; if (chip_ready !== 8'hFD) begin n_fail++; $display("FAIL rdy_low: got %h want FD", chip_ready); end
        req = 8'h06;
        req_wait_rdy = 8'h02;
        tick();
        n_tests++; if (gnt !== 8'h04) begin n_fail++; $display("FAIL rdy_skip_gnt: got %h want 04", gnt); end
        n_tests++; if (gnt_id !== 3'd2) begin n_fail++; $display("FAIL rdy_skip_id: got %0d want 2", gnt_id); end
        req = 8'h02;
        rb_n = 8'hFF;
        tick();
        n_tests++; if (chip_ready !== 8'hFD) begin n_fail++; $display("FAIL rdy_sync1: got %h want FD", chip_ready); end
        tick();
        n_tests++; if (chip_ready !== 8'hFF) begin n_fail++; $display("FAIL rdy_sync2: got %h want FF", chip_ready); end
        n_tests++; if (gnt !== 8'h04) begin n_fail++; $display("FAIL rdy_owner_kept: got %h want 04", gnt); end
        release_pulse = 8'h04;
        tick();
        release_pulse = 8'h00;
        n_tests++; if (gnt !== 8'h00) begin n_fail++; $display("FAIL rdy_rel: got %h want 00", gnt); end
        tick();
        tick();
        n_tests++; if (gnt !== 8'h02) begin n_fail++; $display("FAIL rdy_gnt1: got %h want 02", gnt); end
        n_tests++; if (gnt_id !== 3'd1) begin n_fail++; $display("FAIL rdy_id1: got %0d want 1", gnt_id); end
        release_pulse = 8'h02;
        req = 8'h00;
        req_wait_rdy = 8'h00;
        tick();
        release_pulse = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_boundary();
        req = 8'h08;
        tick();
        n_tests++; if (gnt !== 8'h08) begin n_fail++; $display("FAIL bnd_gnt3: got %h want 08", gnt); end
        req = 8'h00;
        release_pulse = 8'h20;
        tick();
        release_pulse = 8'h00;
        n_tests++; if (gnt !== 8'h08) begin n_fail++; $display("FAIL bnd_nonowner_rel: got %h want 08", gnt); end
        release_pulse = 8'h08;
        req = 8'h01;
        tick();
        release_pulse = 8'h00;
        n_tests++; if (gnt !== 8'h00) begin n_fail++; $display("FAIL bnd_rel_newreq_t1: got %h want 00", gnt); end
        tick();
        n_tests++; if (gnt !== 8'h00) begin n_fail++; $display("FAIL bnd_rel_newreq_t2: got %h want 00", gnt); end
        tick();
        n_tests++; if (gnt !== 8'h01) begin n_fail++; $display("FAIL bnd_rel_newreq_gnt: got %h want 01", gnt); end
        req = 8'h00;
        release_pulse = 8'h01;
        tick();
        release_pulse = 8'h00;
        req = 8'h40;
        tick();
        req = 8'h00;
        tick();
        n_tests++; if (gnt !== 8'h00) begin n_fail++; $display("FAIL bnd_req_dropped: got %h want 00", gnt); end
        release_pulse = 8'hFF;
        tick();
        release_pulse = 8'h00;
        n_tests++; if (gnt !== 8'h00) begin n_fail++; $display("FAIL bnd_idle_rel: got %h want 00", gnt); end
        req = 8'h10;
        tick();
        n_tests++; if (gnt !== 8'h10) begin n_fail++; $display("FAIL bnd_idle_latency: got %h want 10", gnt); end
        n_tests++; if (gnt_id !== 3'd4) begin n_fail++; $display("FAIL bnd_idle_id: got %0d want 4", gnt_id); end
        RST = 1'b1;
        req = 8'h00;
        tick();
        n_tests++; if (gnt !== 8'h00) begin n_fail++; $display("FAIL bnd_midrst_gnt: got %h want 00", gnt); end
        n_tests++; if (cen !== 8'hFF) begin n_fail++; $display("FAIL bnd_midrst_cen: got %h want FF", cen); end
        n_tests++; if (chip_ready !== 8'h00) begin n_fail++; $display("FAIL bnd_midrst_rdy: got %h want 00", chip_ready); end
        n_tests++; if (gnt_id !== 3'd0) begin n_fail++; $display("FAIL bnd_midrst_id: got %0d want 0", gnt_id); end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_watchdog();
        req = 8'h10;
        tick();
        n_tests++; if (gnt !== 8'h10) begin n_fail++; $display("FAIL wd_gnt4: got %h want 10", gnt); end
        req = 8'h00;
`ifdef NAND_ARB_WATCHDOG_EN
        for (int c = 1; c < 16; c++) begin
            n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL wd_early c%0d: got %b want 0", c, timeout_err); end
            tick();
        end
        n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL wd_pulse: got %b want 1", timeout_err); end
        n_tests++; if (gnt !== 8'h10) begin n_fail++; $display("FAIL wd_gnt_at_limit: got %h want 10", gnt); end
        tick();
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL wd_pulse_end: got %b want 0", timeout_err); end
        n_tests++; if (cen !== 8'hFF) begin n_fail++; $display("FAIL wd_cen: got %h want FF", cen); end
        req = 8'h30;
        tick();
        tick();
        n_tests++; if (gnt !== 8'h20) begin n_fail++; $display("FAIL wd_ptr5: got %h want 20", gnt); end
        req = 8'h00;
        release_pulse = 8'h20;
        tick();
        release_pulse = 8'h00;
`else
        for (int c = 0; c < 100; c++) begin
            n_tests++; if (gnt !== 8'h10) begin n_fail++; $display("FAIL wd_hold c%0d: got %h want 10", c, gnt); end
            n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL wd_none c%0d: got %b want 0", c, timeout_err); end
            tick();
        end
        release_pulse = 8'h10;
        tick();
        release_pulse = 8'h00;
        n_tests++; if (cen !== 8'hFF) begin n_fail++; $display("FAIL wd_manual_rel: got %h want FF", cen); end
`endif
        tick();
        tick();
    endtask

    initial begin
        RST = 1'b1;
        req = 8'h00;
        req_wait_rdy = 8'h00;
        release_pulse = 8'h00;
        rb_n = 8'hFF;
        test_reset();
        test_single();
        test_rotation();
        test_wait_rdy();
        test_boundary();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
